// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: shared types and SSD1306 command constants for the
// SPI transmitter and the upstream command/framebuffer sequencers.
package ssd1306_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_LO,
        SCK_HI,
        HOLD,
        GAP
    } state_e;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } spi_word_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam logic [7:0] CMD_ENTIRE_ON_RAM = 8'hA4;
    localparam logic [7:0] CMD_ENTIRE_ON     = 8'hA5;
    localparam logic [7:0] CMD_NORMAL_DISP   = 8'hA6;
    localparam logic [7:0] CMD_INVERSE_DISP  = 8'hA7;
    localparam logic [7:0] CMD_DISPLAY_OFF   = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON    = 8'hAF;
    localparam logic [7:0] CMD_SEG_REMAP_0   = 8'hA0;
    localparam logic [7:0] CMD_SEG_REMAP_127 = 8'hA1;
    localparam logic [7:0] CMD_COM_SCAN_INC  = 8'hC0;
    localparam logic [7:0] CMD_COM_SCAN_DEC  = 8'hC8;
    localparam logic [7:0] CMD_ADDR_MODE     = 8'h20;

    localparam logic [1:0] ADDR_MODE_HORIZ = 2'd0;
    localparam logic [1:0] ADDR_MODE_VERT  = 2'd1;
    localparam logic [1:0] ADDR_MODE_PAGE  = 2'd2;

    function automatic spi_word_t make_word(
        input logic       dc,
        input logic [7:0] data
    );
        spi_word_t w;
        w.dc   = dc;
        w.data = data;
        return w;
    endfunction

    function automatic int max4(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 1) m = 1;
        return m;
    endfunction

endpackage

// File: rtl/ssd1306_spi4_master.sv
// ssd1306_spi4_master: SPI mode-0, MSB-first byte transmitter for SSD1306.
// Every accepted {dc, byte} word is sent in its own chip-select frame.
module ssd1306_spi4_master
    import ssd1306_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        dc_i,
    input  logic [7:0]  data_i,
    output logic        cs_on,
    output logic        sck_o,
    output logic        sdi_o,
    output logic        dc_o,
    output logic        busy_o,
    output logic [15:0] tx_count_o
);

    localparam int CNT_MAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LD_DIV   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(CS_GAP - 1);

    if (CLK_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 || CS_GAP < 1) begin : g_bad_param
        $fatal(1, "ssd1306_spi4_master: timing parameters must be >= 1");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          dc_q, dc_d;
    logic [15:0]   tx_q, tx_d;

    logic          cs_d;
    logic          sck_d;
    logic          rdy_d;
    logic          busy_d;
    logic          accept;
    spi_word_t     word_in;

    assign word_in = make_word(dc_i, data_i);
    assign accept  = valid_i && ready_o;

    // Frame sequencing: one phase counter reloaded on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        dc_d    = dc_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = LD_SETUP;
                    sh_d    = word_in.data;
                    dc_d    = word_in.dc;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = SCK_LO;
                    cnt_d   = LD_DIV;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SCK_LO: begin
                if (cnt_q == '0) begin
                    state_d = SCK_HI;
                    cnt_d   = LD_DIV;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SCK_HI: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (bit_q == 3'd7) begin
                    state_d = HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    state_d = SCK_LO;
                    cnt_d   = LD_DIV;
                    bit_d   = bit_q + 3'd1;
                    sh_d    = {sh_q[6:0], 1'b0};
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = LD_GAP;
                    tx_d    = tx_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin levels follow the next state so they change with the state flop
    always_comb begin
        cs_d   = 1'b1;
        sck_d  = 1'b0;
        rdy_d  = 1'b0;
        busy_d = 1'b1;
        unique case (1'b1)
            (state_d == IDLE): begin
                rdy_d  = 1'b1;
                busy_d = 1'b0;
            end
            (state_d == SCK_HI): begin
                cs_d  = 1'b0;
                sck_d = 1'b1;
            end
            (state_d == SETUP),
            (state_d == SCK_LO),
            (state_d == HOLD): begin
                cs_d = 1'b0;
            end
            default: begin
                cs_d = 1'b1;
            end
        endcase
    end

    // FSM state, phase counter and shift datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            dc_q    <= 1'b0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dc_q    <= dc_d;
            tx_q    <= tx_d;
        end
    end

    // Registered panel pins and handshake flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_on   <= 1'b1;
            sck_o   <= 1'b0;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            cs_on   <= cs_d;
            sck_o   <= sck_d;
            ready_o <= rdy_d;
            busy_o  <= busy_d;
        end
    end

    assign sdi_o      = sh_q[7];
    assign dc_o       = dc_q;
    assign tx_count_o = tx_q;

endmodule

// File: doc/ssd1306_spi4_master.md
Name: ssd1306_spi4_master

Overview:
Synthesizable SPI 4-wire transmitter that drives an SSD1306 display, or the SSD1306 SPI4 simulation model in simulation. It accepts {dc, byte} words over a valid/ready handshake. Each byte is sent as its own chip-select frame, in SPI mode 0, MSB first. It sits between the display-command/framebuffer sequencer upstream and the panel pins downstream.

Parameters:
CLK_DIV, 4, sck half-period in clk_i cycles (>=1)
CS_SETUP, 2, clk_i cycles from cs_on fall to first sck phase (>=1)
CS_HOLD, 2, clk_i cycles from last sck fall to cs_on rise (>=1)
CS_GAP, 2, clk_i cycles cs_on stays high before ready_o reasserts (>=1)

Ports:
clk_i  in  1  system clock; single clock domain
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  upstream word valid
ready_o  out  1  block can accept a word
dc_i  in  1  0 = command, 1 = data
data_i  in  8  byte to send
cs_on  out  1  chip select, active low
sck_o  out  1  serial clock, idle low
sdi_o  out  1  serial data
dc_o  out  1  data/command line
busy_o  out  1  frame in progress (state != IDLE)
tx_count_o  out  16  bytes fully sent; wraps at 2^16

Behaviour:
- Reset values: cs_on=1, sck_o=0, sdi_o=0, dc_o=0, ready_o=0, busy_o=0, tx_count_o=0; state IDLE. ready_o rises in the first cycle after rst_i deasserts.
- FSM states: IDLE, SETUP, SCK_LO, SCK_HI, HOLD, GAP. Each state has one down-counter; the counter width is $clog2(max param + 1).
- IDLE: ready_o=1. valid_i&&ready_o in cycle 0 latches dc_i and data_i, then goes to SETUP.
- SETUP (cycle 1 on): cs_on=0, dc_o=latched dc, sdi_o=bit7. Lasts CS_SETUP cycles, then SCK_LO.
- SCK_LO: sck_o=0 for CLK_DIV cycles, then SCK_HI. On entry from SCK_HI, sdi_o shifts to the next bit, so it changes on the sck falling edge.
- SCK_HI: sck_o=1 for CLK_DIV cycles. The receiver samples on the rising edge. After 8 high phases, go to HOLD with sck_o=0.
- HOLD: sck_o=0, cs_on=0 for CS_HOLD cycles. Then cs_on=1, tx_count_o+1, go to GAP.
- GAP: cs_on=1 for CS_GAP cycles, then IDLE with ready_o=1.
- dc_o is stable from the cs_on fall until the cycle after the cs_on rise. The receiver samples dc at the cs rise.
- dc_o keeps its last value while IDLE.
- cs_on is low for exactly CS_SETUP + 16*CLK_DIV + CS_HOLD cycles.
- ready_o reasserts at cycle 1 + CS_SETUP + 16*CLK_DIV + CS_HOLD + CS_GAP after acceptance. With defaults this is 71.
- Exactly 8 sck rising edges per frame; no sck edge while cs_on=1.
- valid_i while ready_o=0 is ignored. Inputs are not sampled outside the handshake cycle, so changes to data_i or dc_i mid-frame have no effect.
- Back-to-back: if valid_i is high when IDLE is entered, acceptance happens in that first IDLE cycle. The minimum inter-frame cs_on high time is CS_GAP + 1 cycles.
- rst_i mid-frame: next cycle forces reset values (cs_on=1, sck_o=0), abandons the partial byte, and leaves tx_count_o at 0. The receiver discards frames that are not 8 bits.
- tx_count_o wraps 0xFFFF -> 0x0000 without a flag.
- Parameter < 1 gives a $fatal at elaboration.

Decomposition:
- Shared package ssd1306_pkg holds:
  - the state enum (state_e);
  - typedef spi_word_t {logic dc; logic [7:0] data};
  - SSD1306 command constants: 0xA4/A5 entire-on, 0xA6/A7 inverse, 0xAE/AF on/off, 0xA0/A1 segment remap, 0xC0/C8 COM dir, 0x20 address mode;
  - address-mode encodings: 0 horizontal, 1 vertical, 2 page.
- Upstream sequencers reuse the package.
- No sub-module. The FSM, shift register and single phase counter fit in one module.

Test Plan:
1. Hold rst_i 3 cycles -> all outputs at their reset values; ready_o=1 in the cycle after rst_i falls; busy_o=0.
2. Send dc=0, 0xAF with defaults -> bits sampled at sck rise are 1,0,1,0,1,1,1,1; dc_o=0 throughout cs_on low; cs_on low 68 cycles; ready_o back at cycle 71; tx_count_o=1; the SSD1306 model reports onoff=true.
3. Stream dc=0 0x20, dc=0 0x00, dc=1 0x55 with valid_i held -> three separate frames; cs_on high >=3 cycles between them; tx_count_o=3; the model sets horizontal mode and writes 0x55 at x=0, y=0.
4. Change data_i/dc_i to 0xFF/1 during an active 0x3C command frame -> 0x3C with dc=0 is shifted; the new word is accepted only when ready_o=1.
5. Assert rst_i after the 3rd sck rise -> next cycle cs_on=1 and sck_o=0; tx_count_o=0; no further sck edges; the model issues no command or data for the partial frame.
6. Use CLK_DIV=1, CS_SETUP=CS_HOLD=CS_GAP=1 and send 0xA7 -> sck period 2 cycles, cs_on low 18 cycles, ready_o back at cycle 20; the model reports inverse=true.
